mux_scan_sampler: RTL and testbench
===================================

# mux_scan_sampler

Sequential select driver and sampler for the team's 16:1 mux models; it sits upstream and downstream of the mux at once. On a start request it steps the mux select `S` through 0..N-1. After each select change it waits a programmable number of settle cycles, covering the mux propagation delay, then samples the mux output `w`. Each sample is emitted as a serial bit with a valid strobe, and the full reassembled word is presented with a one-cycle done pulse.

## Interface
- `SEL_W`, default 4: select width; N = 2**SEL_W mux inputs.
- `SETTLE_CYC`, default 11: clocks between a select change and its sample; legal range is ≥1. With a 10 ns clock, 11 covers the 105 ns worst-case 16:1 CMOS mux delay.
- `clk`, in, 1: single clock; all state changes on its rising edge.
- `rst`, in, 1: reset is asynchronous and active-high.
- `start`, in, 1: run request; sampled only in IDLE.
- `S`, out, SEL_W: mux select, registered.
- `w`, in, 1: mux output; may be X between samples.
- `busy`, out, 1: high in SETTLE and DONE.
- `bit_out`, out, 1: most recent sample.
- `bit_valid`, out, 1: one-cycle strobe, high in the cycle after each sample edge.
- `bit_idx`, out, SEL_W: select value that produced `bit_out`.
- `word_out`, out, [0:N-1]: bit i = sample taken with S=i.
- `done`, out, 1: one-cycle pulse; `word_out` is complete and stable while high.

## Operation
- Reset values (asynchronous, immediate, including mid-run):
  - state = IDLE, `S`=0, settle counter = 0.
  - `busy`, `bit_out`, `bit_valid`, `done` = 0.
  - `bit_idx`=0, `word_out` all 0, internal capture register = 0.
- States: IDLE, SETTLE, DONE.
- IDLE:
  - `start`=1 at an edge → `S`<=0, counter<=SETTLE_CYC-1, go SETTLE.
  - `start`=0 → stay; outputs hold their last values except strobes (`bit_valid`, `done`), which are 0.
- SETTLE, counter≠0: counter decrements by 1; `S` holds.
- SETTLE, counter==0 (sample edge):
  - capture[S]<=`w`, `bit_out`<=`w`, `bit_idx`<=`S`, `bit_valid`<=1.
  - If `S`==N-1: `word_out`<=capture with bit N-1 replaced by `w`, `done`<=1, go DONE.
  - Otherwise: `S`<=`S`+1, counter<=SETTLE_CYC-1.
- DONE: lasts exactly one cycle, then IDLE. `S` stays at N-1 until the next start.
- `start` is ignored while `busy`=1 and is not queued.
- `word_out` changes only on a completed run; a reset-aborted run never updates it except by clearing it.
- `S` wrap: N-1 never increments to 0 inside a run; a new run reloads 0 explicitly.
- Counter width is clog2(SETTLE_CYC), minimum 1 bit. SETTLE_CYC=1 samples on every edge.

## Timing
- `start` accepted at edge k → `S`=0 after edge k; `busy`=1 from edge k.
- Sample i (i=0..N-1) at edge k+(i+1)·SETTLE_CYC; `S`=i is held for SETTLE_CYC full cycles before that edge.
- `bit_valid` and `done` are high for exactly one cycle after their edge; `done` coincides with `bit_valid` for i=N-1.
- Run latency is N·SETTLE_CYC cycles from accept edge to `done` rising.
  - Default: 176 cycles.
  - `busy` falls at edge k+N·SETTLE_CYC+1.
- With `start` held high, the next accept is at edge k+N·SETTLE_CYC+2: one IDLE cycle between runs.
- `w` is sampled only at sample edges; X at any other time must not reach outputs.

## Test plan
- **Reset:** assert `rst` with the clock stopped → all outputs 0 immediately; release, idle 20 cycles → no change, `busy`=0.
- **Default run:** SETTLE_CYC=11, mux inputs [0:15]=1010_0101_1100_0011, `start` pulse at edge 0 → 16 `bit_valid` strobes at edges 11,22,…,176 with `bit_idx` 0..15 and matching bits; `done` high one cycle after edge 176; `word_out`=1010_0101_1100_0011.
- **Settle boundary:** SETTLE_CYC=3; `w` driven X except in the final settle cycle of each index → `word_out` fully defined and correct; no X on `bit_out`.
- **Held start:** `start` held high through two runs → second accept at edge 178 (default); no accept between edges 1 and 177.
- **Mid-run reset:** assert `rst` asynchronously while `S`=7 → `S`=0, `word_out`=0, `busy`=0 within the same cycle; a new start reruns from S=0 with correct data.
- **Minimum settle:** SETTLE_CYC=1, mux inputs 0xFFFF → samples at 16 consecutive edges, `done` after edge 16, `word_out`=all ones.

Source files
------------

// File: rtl/mux_scan_sampler.sv
// Steps a 16:1 mux select through every input, waits SETTLE_CYC clocks after each
// change for the mux to settle, samples its output, streams each bit and presents the word.
module mux_scan_sampler #(
    parameter int SEL_W      = 4,
    parameter int SETTLE_CYC = 11
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic [SEL_W-1:0]         S,
    input  logic                     w,
    output logic                     busy,
    output logic                     bit_out,
    output logic                     bit_valid,
    output logic [SEL_W-1:0]         bit_idx,
    output logic [0:(1<<SEL_W)-1]    word_out,
    output logic                     done
);
    localparam int N     = 1 << SEL_W;
    localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYC - 1);
    localparam logic [SEL_W-1:0] SEL_MAX  = {SEL_W{1'b1}};

    typedef enum logic [1:0] {IDLE, SETTLE, DONE} state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [SEL_W-1:0] sel_n;
    logic [0:N-1]     cap, cap_n;
    logic [0:N-1]     word_n;
    logic             bit_n, bv_n, done_n;
    logic [SEL_W-1:0] idx_n;

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            S         <= '0;
            cnt       <= '0;
            cap       <= '0;
            word_out  <= '0;
            bit_out   <= 1'b0;
            bit_valid <= 1'b0;
            bit_idx   <= '0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            S         <= sel_n;
            cnt       <= cnt_n;
            cap       <= cap_n;
            word_out  <= word_n;
            bit_out   <= bit_n;
            bit_valid <= bv_n;
            bit_idx   <= idx_n;
            done      <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        sel_n   = S;
        cnt_n   = cnt;
        cap_n   = cap;
        word_n  = word_out;
        bit_n   = bit_out;
        idx_n   = bit_idx;
        bv_n    = 1'b0;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    sel_n   = '0;
                    cnt_n   = CNT_LOAD;
                    state_n = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt != '0) begin
                    cnt_n = cnt - 1'b1;
                end else begin
                    // w is only looked at here; it may be X at any other time.
                    cap_n[S] = w;
                    bit_n    = w;
                    idx_n    = S;
                    bv_n     = 1'b1;
                    if (S == SEL_MAX) begin
                        word_n      = cap;
                        word_n[N-1] = w;
                        done_n      = 1'b1;
                        state_n     = DONE;
                    end else begin
                        sel_n = S + 1'b1;
                        cnt_n = CNT_LOAD;
                    end
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_mux_scan_sampler.sv
// Bench for mux_scan_sampler: three instances (settle 11, 3, 1) with a behavioural mux
// in front of each and a scoreboard of expected serial bits keyed by edge number.
module tb_mux_scan_sampler;
    logic clk = 1'b0;
    logic clk_en = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    typedef struct { int idx; logic b; int rel; } exp_t;
    exp_t q[$];
    exp_t e;

    logic        start_a = 0, start_b = 0, start_c = 0;
    logic [3:0]  s_a, s_b, s_c, idx_a, idx_b, idx_c;
    logic        w_a, w_b, w_c;
    logic        busy_a, busy_b, busy_c, bit_a, bit_b, bit_c;
    logic        bv_a, bv_b, bv_c, done_a, done_b, done_c;
    logic [0:15] word_a, word_b, word_c;
    logic [0:15] mux_a = '0, mux_b = '0, mux_c = '0;
    logic        dirty_b = 1'b0;

    assign w_a = mux_a[s_a];
    // Outside the final settle cycle the B mux output is deliberately wrong.
    assign w_b = mux_b[s_b] ^ dirty_b;
    assign w_c = mux_c[s_c];

    mux_scan_sampler #(.SEL_W(4), .SETTLE_CYC(11)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .S(s_a), .w(w_a), .busy(busy_a),
        .bit_out(bit_a), .bit_valid(bv_a), .bit_idx(idx_a), .word_out(word_a), .done(done_a));
    mux_scan_sampler #(.SEL_W(4), .SETTLE_CYC(3)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .S(s_b), .w(w_b), .busy(busy_b),
        .bit_out(bit_b), .bit_valid(bv_b), .bit_idx(idx_b), .word_out(word_b), .done(done_b));
    mux_scan_sampler #(.SEL_W(4), .SETTLE_CYC(1)) dut_c (
        .clk(clk), .rst(rst), .start(start_c), .S(s_c), .w(w_c), .busy(busy_c),
        .bit_out(bit_c), .bit_valid(bv_c), .bit_idx(idx_c), .word_out(word_c), .done(done_c));

    always #5 if (clk_en) clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic test_reset();
        rst = 1'b0;
        #3 rst = 1'b1;
        #1;
        checks++;
        if ({s_a, busy_a, bit_a, bv_a, idx_a, word_a, done_a} !== '0) begin
            errors++;
            $display("FAIL reset_a got S=%0d busy=%b bit=%b bv=%b idx=%0d word=%h done=%b want all 0",
                     s_a, busy_a, bit_a, bv_a, idx_a, word_a, done_a);
        end
        checks++;
        if ({s_b, busy_b, bit_b, bv_b, idx_b, word_b, done_b,
             s_c, busy_c, bit_c, bv_c, idx_c, word_c, done_c} !== '0) begin
            errors++;
            $display("FAIL reset_bc got word_b=%h word_c=%h S_b=%0d S_c=%0d want all 0",
                     word_b, word_c, s_b, s_c);
        end
        #5 rst = 1'b0;
        clk_en = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            checks++;
            if ({s_a, busy_a, bv_a, done_a, word_a, busy_c, bv_c} !== '0) begin
                errors++;
                $display("FAIL idle_hold cycle %0d got S=%0d busy=%b bv=%b done=%b word=%h want 0",
                         n, s_a, busy_a, bv_a, done_a, word_a);
            end
        end
    endtask

    task automatic test_default_run(input logic [0:15] pat);
        int k, rel, ndone;
        mux_a = pat;
        q.delete();
        for (int i = 0; i < 16; i++) begin
            e.idx = i; e.b = pat[i]; e.rel = 11 * (i + 1);
            q.push_back(e);
        end
        @(negedge clk) start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
        k = cyc;
        ndone = 0;
        checks++;
        if (busy_a !== 1'b1 || s_a !== 4'd0) begin
            errors++;
            $display("FAIL accept got busy=%b S=%0d want busy=1 S=0", busy_a, s_a);
        end
        for (int n = 1; n <= 179; n++) begin
            @(negedge clk);
            rel = cyc - k;
            if (bv_a) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_bit_a got idx %0d at edge %0d want none", idx_a, rel);
                end else begin
                    e = q.pop_front();
                    if (idx_a !== e.idx[3:0] || bit_a !== e.b || rel != e.rel) begin
                        errors++;
                        $display("FAIL bit_a got idx %0d bit %b edge %0d want idx %0d bit %b edge %0d",
                                 idx_a, bit_a, rel, e.idx, e.b, e.rel);
                    end
                end
            end
            if (rel % 11 == 10 && rel < 176) begin
                checks++;
                if (s_a !== 4'(rel / 11)) begin
                    errors++;
                    $display("FAIL sel_hold edge %0d got S=%0d want %0d", rel, s_a, rel / 11);
                end
            end
            if (done_a) begin
                ndone++;
                checks++;
                if (rel != 176 || word_a !== pat || bv_a !== 1'b1) begin
                    errors++;
                    $display("FAIL done_a got edge %0d word %h bv %b want edge 176 word %h bv 1",
                             rel, word_a, bv_a, pat);
                end
            end
            if (rel == 177) begin
                checks++;
                if (busy_a !== 1'b0 || word_a !== pat || s_a !== 4'd15) begin
                    errors++;
                    $display("FAIL after_run got busy=%b word=%h S=%0d want busy=0 word=%h S=15",
                             busy_a, word_a, s_a, pat);
                end
            end
        end
        checks++;
        if (ndone != 1 || q.size() != 0) begin
            errors++;
            $display("FAIL run_end got dones %0d pending %0d want 1 and 0", ndone, q.size());
        end
    endtask

    task automatic test_held_start();
        int k, rel, ndone, rises;
        logic last_busy;
        logic [0:15] pat;
        pat = 16'h3C5A;
        mux_a = pat;
        q.delete();
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < 16; i++) begin
                e.idx = i; e.b = pat[i]; e.rel = 178 * r + 11 * (i + 1);
                q.push_back(e);
            end
        @(negedge clk) start_a = 1'b1;
        @(negedge clk);
        k = cyc;
        ndone = 0;
        rises = 0;
        last_busy = busy_a;
        for (int n = 1; n <= 355; n++) begin
            @(negedge clk);
            rel = cyc - k;
            if (bv_a) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_bit_held got idx %0d at edge %0d want none", idx_a, rel);
                end else begin
                    e = q.pop_front();
                    if (idx_a !== e.idx[3:0] || bit_a !== e.b || rel != e.rel) begin
                        errors++;
                        $display("FAIL bit_held got idx %0d bit %b edge %0d want idx %0d bit %b edge %0d",
                                 idx_a, bit_a, rel, e.idx, e.b, e.rel);
                    end
                end
            end
            if (busy_a && !last_busy) begin
                rises++;
                checks++;
                if (rel != 178 || s_a !== 4'd0) begin
                    errors++;
                    $display("FAIL reaccept got edge %0d S=%0d want edge 178 S=0", rel, s_a);
                end
            end
            if (done_a) ndone++;
            last_busy = busy_a;
        end
        start_a = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (rises != 1 || ndone != 2 || q.size() != 0 || busy_a !== 1'b0) begin
            errors++;
            $display("FAIL held_end got accepts %0d dones %0d pending %0d busy %b want 1 2 0 0",
                     rises, ndone, q.size(), busy_a);
        end
    endtask

    task automatic test_mid_run_reset();
        mux_a = 16'hFFFF;
        @(negedge clk) start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
        for (int n = 0; n < 200 && s_a != 4'd7; n++) @(negedge clk);
        checks++;
        if (s_a !== 4'd7) begin
            errors++;
            $display("FAIL reach_s7 got S=%0d want 7", s_a);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (s_a !== 4'd0 || word_a !== 16'h0 || busy_a !== 1'b0 || bit_a !== 1'b0 || idx_a !== 4'd0) begin
            errors++;
            $display("FAIL midrun_reset got S=%0d word=%h busy=%b bit=%b idx=%0d want all 0",
                     s_a, word_a, busy_a, bit_a, idx_a);
        end
        @(negedge clk) rst = 1'b0;
        test_default_run(16'h5AC3);
    endtask

    task automatic test_settle_boundary();
        int k, rel, ndone;
        logic [0:15] pat;
        pat = 16'h6D93;
        mux_b = pat;
        q.delete();
        for (int i = 0; i < 16; i++) begin
            e.idx = i; e.b = pat[i]; e.rel = 3 * (i + 1);
            q.push_back(e);
        end
        @(negedge clk) begin start_b = 1'b1; dirty_b = 1'b1; end
        @(negedge clk) start_b = 1'b0;
        k = cyc;
        ndone = 0;
        dirty_b = 1'b1;
        for (int n = 1; n <= 50; n++) begin
            @(negedge clk);
            rel = cyc - k;
            dirty_b = ((rel + 1) % 3 != 0);
            if (bv_b) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_bit_b got idx %0d at edge %0d want none", idx_b, rel);
                end else begin
                    e = q.pop_front();
                    if (idx_b !== e.idx[3:0] || bit_b !== e.b || rel != e.rel) begin
                        errors++;
                        $display("FAIL bit_b got idx %0d bit %b edge %0d want idx %0d bit %b edge %0d",
                                 idx_b, bit_b, rel, e.idx, e.b, e.rel);
                    end
                end
            end
            if (done_b) begin
                ndone++;
                checks++;
                if (rel != 48 || word_b !== pat) begin
                    errors++;
                    $display("FAIL done_b got edge %0d word %h want edge 48 word %h", rel, word_b, pat);
                end
            end
        end
        dirty_b = 1'b0;
        checks++;
        if (ndone != 1 || q.size() != 0 || busy_b !== 1'b0) begin
            errors++;
            $display("FAIL settle_end got dones %0d pending %0d busy %b want 1 0 0", ndone, q.size(), busy_b);
        end
    endtask

    task automatic test_min_settle();
        int k, rel, ndone;
        mux_c = 16'hFFFF;
        q.delete();
        for (int i = 0; i < 16; i++) begin
            e.idx = i; e.b = 1'b1; e.rel = i + 1;
            q.push_back(e);
        end
        @(negedge clk) start_c = 1'b1;
        @(negedge clk) start_c = 1'b0;
        k = cyc;
        ndone = 0;
        for (int n = 1; n <= 19; n++) begin
            @(negedge clk);
            rel = cyc - k;
            if (bv_c) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_bit_c got idx %0d at edge %0d want none", idx_c, rel);
                end else begin
                    e = q.pop_front();
                    if (idx_c !== e.idx[3:0] || bit_c !== e.b || rel != e.rel) begin
                        errors++;
                        $display("FAIL bit_c got idx %0d bit %b edge %0d want idx %0d bit %b edge %0d",
                                 idx_c, bit_c, rel, e.idx, e.b, e.rel);
                    end
                end
            end
            if (done_c) begin
                ndone++;
                checks++;
                if (rel != 16 || word_c !== 16'hFFFF) begin
                    errors++;
                    $display("FAIL done_c got edge %0d word %h want edge 16 word ffff", rel, word_c);
                end
            end
        end
        checks++;
        if (ndone != 1 || q.size() != 0 || busy_c !== 1'b0) begin
            errors++;
            $display("FAIL min_end got dones %0d pending %0d busy %b want 1 0 0", ndone, q.size(), busy_c);
        end
    endtask

    initial begin
        test_reset();
        test_default_run(16'hA5C3);
        test_held_start();
        test_mid_run_reset();
        test_settle_boundary();
        test_min_settle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
